imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Instruction memory plus boot-loader front end for the 8-bit pipelined core.
- Accepts a program as a byte stream over a valid/ready load port and writes it from address 0 upward. Holds the core in reset while loading, then releases it.
- Serves the fetch side with two combinational reads: instr = M[fetch_addr] for the fetch stage, and mem0 = M[0] as the PC reset vector.
- The PC register loads mem0 while cpu_reset is high and advances from pc_out once released.

Parameters:
AW, 8, address width; memory depth is 2**AW.
DW, 8, data/instruction width.
RELEASE_CYCLES, 2, cycles cpu_reset stays high after the last byte is written (range 1..15).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low block reset.
ld_start  in  1  single-cycle pulse requesting a (re)load.
ld_valid  in  1  load byte valid.
ld_data  in  DW  load byte.
ld_last  in  1  marks the final byte; qualified by ld_valid.
ld_ready  out  1  block can accept a byte this cycle.
fetch_addr  in  AW  PC value (pc_out) from fetch.
instr  out  DW  M[fetch_addr], combinational.
mem0  out  DW  M[0], combinational; PC reset vector.
cpu_reset  out  1  synchronous active-high reset to PC and pipeline.
ld_count  out  AW+1  bytes written in the current or last load.
ld_err  out  1  sticky overflow flag (memory filled without ld_last).

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=BOOT, ld_addr=0, ld_count=0, ld_err=0, cpu_reset=1, ld_ready=0.
  - Memory contents are NOT reset; they are retained.
- States: BOOT, LOAD, RELEASE, RUN.
- BOOT: cpu_reset=1, ld_ready=0. ld_start -> LOAD; ld_addr=0, ld_count=0, ld_err=0.
- LOAD: cpu_reset=1, ld_ready=1.
  - Accept = ld_valid & ld_ready. On accept: M[ld_addr] <= ld_data, ld_addr+1, ld_count+1.
  - Accept with ld_last -> RELEASE, relcnt=RELEASE_CYCLES-1.
  - Accept at ld_addr=2**AW-1 without ld_last: ld_err<=1, ld_addr wraps to 0, -> RELEASE. Further bytes are not written.
  - ld_start ignored. No accept: hold state.
- RELEASE: cpu_reset=1, ld_ready=0. relcnt decrements each cycle; relcnt==0 -> RUN.
  - The final write lands by the RELEASE entry edge, so the PC samples the updated mem0 at least once.
- RUN: cpu_reset=0, ld_ready=0. ld_start -> LOAD with the same initialisation as from BOOT; cpu_reset=1 from the next cycle.
- Load latency: cpu_reset deasserts exactly RELEASE_CYCLES+1 clocks after the last-byte accept edge. With default 2, it is low starting 3 cycles later.
- ld_start and ld_valid together in BOOT/RUN: ld_start wins; the byte is not accepted (ld_ready=0).
- cpu_reset, ld_ready, ld_count, ld_err are registered or decoded from registered state only; no combinational path from load inputs.
- instr and mem0 are asynchronous reads. A write to M[a] is visible on instr/mem0 the cycle after the accepting edge.
- Reset mid-LOAD: back to BOOT; partial contents kept; cpu_reset held high until a new load completes.
- ld_count saturates naturally at 2**AW (width AW+1).

Decomposition:
- Shared package: state encoding enum (BOOT, LOAD, RELEASE, RUN) and the default AW/DW constants used across the core.
- One natural sub-module, imem_ram: 2**AW x DW array with one synchronous write port and two asynchronous read ports (instr, mem0).
- FSM and counters stay in imem_loader.

Test Plan:
- Reset then ld_start; stream 0x10,0x22,0x33 with ld_last on 0x33 -> ld_count=3, mem0=0x10, cpu_reset low exactly 3 cycles after the last accept; instr=0x22 at fetch_addr=1.
- Stall the stream with ld_valid=0 for 5 cycles mid-load -> no writes, ld_ready stays 1, cpu_reset stays 1, ld_addr unchanged.
- Stream 256 bytes with no ld_last -> ld_err=1, ld_count=256, transition to RELEASE; a 257th byte is not written and M[0] is unchanged.
- In RUN, pulse ld_start and load 0x5A,0x01 (last) -> cpu_reset reasserts next cycle; mem0=0x5A after the reload; ld_err cleared; M[2..] keep their old values.
- Assert reset (low) mid-load after 2 bytes -> immediately BOOT, cpu_reset=1, ld_ready=0; the 2 written bytes still readable on instr.
- ld_start and ld_valid asserted together in BOOT -> enters LOAD, nothing written that cycle, ld_count=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// loader FSM state encoding and default memory geometry.
package imem_loader_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_if.sv
// Program-load byte stream: start pulse plus a valid/ready byte channel
// with an end-of-program marker.
interface imem_loader_if #(
  parameter int DW = imem_loader_pkg::DW_DEF
);
  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    output ld_ready
  );
endinterface : imem_loader_if

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port, two asynchronous
// read ports (fetch-stage instruction and the word at address 0).
module imem_ram #(
  parameter int AW = imem_loader_pkg::AW_DEF,
  parameter int DW = imem_loader_pkg::DW_DEF
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  output logic [DW-1:0] o_rdata0
);

  logic [DW-1:0] r_mem [2**AW];

  // Byte write from the load stream.
  // NOTE: the array has no reset; program contents must survive a block reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata  = r_mem[i_raddr];
  assign o_rdata0 = r_mem[0];

endmodule : imem_ram

// File: rtl/imem_loader.sv
// Boot loader front end: writes a byte stream into instruction memory
// from address 0 upward, holds the core in reset while loading, then
// releases it after a short settling window.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.slave   ld,
  input  logic [AW-1:0]  fetch_addr,
  output logic [DW-1:0]  instr,
  output logic [DW-1:0]  mem0,
  output logic           cpu_reset,
  output logic [AW:0]    ld_count,
  output logic           ld_err
);

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_count;
  logic          r_err;
  logic [3:0]    r_relcnt;
  logic          r_cpu_reset;

  logic          w_ld_ready;
  logic          w_accept;
  logic          w_at_top;
  logic          w_load_done;

  assign w_ld_ready  = (r_state == ST_LOAD);
  assign w_accept    = ld.ld_valid & w_ld_ready;
  assign w_at_top    = (r_addr == {AW{1'b1}});
  assign w_load_done = w_accept & (ld.ld_last | w_at_top);

  // State register.
  // NOTE: clocked processes use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_BOOT;
    else        r_state <= w_next_state;
  end

  // Next-state decode.
  // NOTE: next state is defaulted to the current state first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_BOOT:    if (ld.ld_start)      w_next_state = ST_LOAD;
      ST_LOAD:    if (w_load_done)      w_next_state = ST_RELEASE;
      ST_RELEASE: if (r_relcnt == 4'd0) w_next_state = ST_RUN;
      ST_RUN:     if (ld.ld_start)      w_next_state = ST_LOAD;
      default:                          w_next_state = ST_BOOT;
    endcase
  end

  // Load address/count, overflow flag, release countdown and core reset.
  // cpu_reset drops one cycle after RUN is reached, so the PC sees the
  // freshly written reset vector, and rises as soon as RUN is left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_relcnt    <= '0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_cpu_reset <= !((r_state == ST_RUN) && (w_next_state == ST_RUN));
      unique case (r_state)
        ST_BOOT, ST_RUN: begin
          if (ld.ld_start) begin
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count + 1'b1;
            if (w_at_top && !ld.ld_last) r_err <= 1'b1;
            if (w_load_done) r_relcnt <= 4'(RELEASE_CYCLES - 1);
          end
        end
        ST_RELEASE: begin
          if (r_relcnt != 4'd0) r_relcnt <= r_relcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  imem_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk      (clk),
    .i_we     (w_accept),
    .i_waddr  (r_addr),
    .i_wdata  (ld.ld_data),
    .i_raddr  (fetch_addr),
    .o_rdata  (instr),
    .o_rdata0 (mem0)
  );

  assign ld.ld_ready = w_ld_ready;
  assign cpu_reset   = r_cpu_reset;
  assign ld_count    = r_count;
  assign ld_err      = r_err;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for the instruction-memory boot loader.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] fetch_addr;
  logic [7:0] instr;
  logic [7:0] mem0;
  logic       cpu_reset;
  logic [8:0] ld_count;
  logic       ld_err;

  int n_checks = 0;
  int n_pass   = 0;

  imem_loader_if #(.DW(8)) ld_if ();

  imem_loader #(.AW(8), .DW(8), .RELEASE_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld         (ld_if.slave),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .mem0       (mem0),
    .cpu_reset  (cpu_reset),
    .ld_count   (ld_count),
    .ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = d;
    ld_if.ld_last  = l;
    tick();
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
    fetch_addr = a;
    #1;
    check(tag, 16'(instr), 16'(exp));
  endtask

  initial begin
    reset          = 1'b0;
    fetch_addr     = '0;
    ld_if.ld_start = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.ld_last  = 1'b0;

    // Reset state
    #12;
    check("rst_cpu_reset", 16'(cpu_reset), 16'd1);
    check("rst_ld_ready",  16'(ld_if.ld_ready), 16'd0);
    check("rst_ld_count",  16'(ld_count), 16'd0);
    check("rst_ld_err",    16'(ld_err), 16'd0);
    tick();
    reset = 1'b1;
    tick();
    check("boot_cpu_reset", 16'(cpu_reset), 16'd1);
    check("boot_ld_ready",  16'(ld_if.ld_ready), 16'd0);

    // Basic 3-byte load with a 5-cycle stall after the first byte
    ld_if.ld_start = 1'b1;
    tick();
    ld_if.ld_start = 1'b0;
    check("load_ready", 16'(ld_if.ld_ready), 16'd1);
    send(8'h10, 1'b0);
    check("b0_count", 16'(ld_count), 16'd1);
    check("b0_mem0",  16'(mem0), 16'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ready", 16'(ld_if.ld_ready), 16'd1);
      check("stall_cpu_reset", 16'(cpu_reset), 16'd1);
      check("stall_count", 16'(ld_count), 16'd1);
    end
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    check("last_count", 16'(ld_count), 16'd3);
    check("last_ready", 16'(ld_if.ld_ready), 16'd0);
    check("last_mem0",  16'(mem0), 16'h10);
    peek(8'd1, 8'h22, "instr_a1");
    peek(8'd2, 8'h33, "instr_a2");
    check("rel_e0_cpu_reset", 16'(cpu_reset), 16'd1);
    tick();
    check("rel_e1_cpu_reset", 16'(cpu_reset), 16'd1);
    tick();
    check("rel_e2_cpu_reset", 16'(cpu_reset), 16'd1);
    tick();
    check("run_e3_cpu_reset", 16'(cpu_reset), 16'd0);

    // Overflow: 256 bytes (i ^ 0xA5) with no ld_last
    ld_if.ld_start = 1'b1;
    tick();
    ld_if.ld_start = 1'b0;
    check("ovf_start_cpu_reset", 16'(cpu_reset), 16'd1);
    check("ovf_start_ready", 16'(ld_if.ld_ready), 16'd1);
    check("ovf_start_count", 16'(ld_count), 16'd0);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        check("ovf_pre_count", 16'(ld_count), 16'd255);
        check("ovf_pre_err", 16'(ld_err), 16'd0);
      end
      send(8'(i) ^ 8'hA5, 1'b0);
    end
    check("ovf_err",   16'(ld_err), 16'd1);
    check("ovf_count", 16'(ld_count), 16'd256);
    check("ovf_ready", 16'(ld_if.ld_ready), 16'd0);
    check("ovf_cpu_reset", 16'(cpu_reset), 16'd1);
    send(8'hFF, 1'b0);
    check("ovf_257_mem0", 16'(mem0), 16'hA5);
    check("ovf_257_count", 16'(ld_count), 16'd256);
    peek(8'd255, 8'h5A, "ovf_instr_a255");
    tick();
    tick();
    check("ovf_run_cpu_reset", 16'(cpu_reset), 16'd0);
    check("ovf_run_err", 16'(ld_err), 16'd1);

    // Reload from RUN: 0x5A, 0x01(last)
    ld_if.ld_start = 1'b1;
    tick();
    ld_if.ld_start = 1'b0;
    check("reload_cpu_reset", 16'(cpu_reset), 16'd1);
    check("reload_err_clr", 16'(ld_err), 16'd0);
    check("reload_count", 16'(ld_count), 16'd0);
    send(8'h5A, 1'b0);
    send(8'h01, 1'b1);
    check("reload_mem0", 16'(mem0), 16'h5A);
    check("reload_count2", 16'(ld_count), 16'd2);
    peek(8'd1, 8'h01, "reload_a1");
    peek(8'd2, 8'hA7, "reload_keep_a2");
    peek(8'd200, 8'h6D, "reload_keep_a200");
    tick();
    tick();
    check("reload_e2_cpu_reset", 16'(cpu_reset), 16'd1);
    tick();
    check("reload_run_cpu_reset", 16'(cpu_reset), 16'd0);

    // Reset in the middle of a load after two bytes
    ld_if.ld_start = 1'b1;
    tick();
    ld_if.ld_start = 1'b0;
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_cpu_reset", 16'(cpu_reset), 16'd1);
    check("mid_rst_ready", 16'(ld_if.ld_ready), 16'd0);
    check("mid_rst_count", 16'(ld_count), 16'd0);
    peek(8'd0, 8'h77, "mid_rst_a0");
    peek(8'd1, 8'h88, "mid_rst_a1");
    peek(8'd2, 8'hA7, "mid_rst_a2");
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("mid_rst_boot_cpu_reset", 16'(cpu_reset), 16'd1);
    check("mid_rst_boot_ready", 16'(ld_if.ld_ready), 16'd0);

    // ld_start together with ld_valid in BOOT: byte is dropped
    ld_if.ld_start = 1'b1;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 8'hEE;
    tick();
    ld_if.ld_start = 1'b0;
    ld_if.ld_valid = 1'b0;
    check("sv_ready", 16'(ld_if.ld_ready), 16'd1);
    check("sv_count", 16'(ld_count), 16'd0);
    check("sv_mem0",  16'(mem0), 16'h77);
    send(8'h99, 1'b1);
    check("sv_load_mem0", 16'(mem0), 16'h99);
    check("sv_load_count", 16'(ld_count), 16'd1);
    tick();
    tick();
    tick();
    check("sv_run_cpu_reset", 16'(cpu_reset), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_imem_loader
